// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared widths, next-PC select codes and fetch FSM states
package instr_fetch_pkg;
    localparam int WORD = 32;

    localparam logic [1:0] ALU_NPC_4      = 2'd0;
    localparam logic [1:0] ALU_NPC_BRANCH = 2'd1;
    localparam logic [1:0] ALU_NPC_JAL    = 2'd2;
    localparam logic [1:0] ALU_NPC_JALR   = 2'd3;

    localparam logic [WORD-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    typedef enum logic [2:0] {RST, FETCH, WAIT, HOLD, HALT} fetch_state_t;
endpackage

// File: rtl/instr_fetch_npc_calc.sv
// npc_calc: combinational next-PC select with misaligned-target flag
module npc_calc
    import instr_fetch_pkg::*;
(
    input  logic [WORD-1:0] pc,
    input  logic [1:0]      pcn_control,
    input  logic [WORD-1:0] imm32,
    input  logic [WORD-1:0] rs1_val,
    input  logic            branch_taken,
    output logic [WORD-1:0] npc,
    output logic            misaligned
);
    logic [WORD-1:0] seq, rel, ind;
    logic            take_rel;

    always_comb begin
        seq        = pc + WORD'(4);
        rel        = pc + imm32;
        ind        = (rs1_val + imm32) & ~WORD'(1);
        take_rel   = pcn_control == ALU_NPC_JAL || (pcn_control == ALU_NPC_BRANCH && branch_taken);
        npc        = pcn_control == ALU_NPC_JALR ? ind : take_rel ? rel : seq;
        misaligned = |npc[1:0];
    end
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC register and one-word-at-a-time fetch FSM feeding the decoder
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [WORD-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [WORD-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [WORD-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [WORD-1:0] imem_rdata,
    output logic [WORD-1:0] instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [WORD-1:0] pc,
    input  logic [1:0]      pcn_control,
    input  logic [WORD-1:0] imm32,
    input  logic [WORD-1:0] rs1_val,
    input  logic            branch_taken,
    input  logic            finish,
    output logic            halted,
    output logic            fetch_err
);
    fetch_state_t    state, state_n;
    logic [WORD-1:0] instr_q, npc;
    logic            misaligned, accept, stop;

    npc_calc u_npc (
        .pc          (pc),
        .pcn_control (pcn_control),
        .imm32       (imm32),
        .rs1_val     (rs1_val),
        .branch_taken(branch_taken),
        .npc         (npc),
        .misaligned  (misaligned)
    );

    assign accept      = state == HOLD && instr_ready;
    assign stop        = finish || misaligned;
    assign imem_req    = state == FETCH;
    assign imem_addr   = pc;
    assign instr_valid = state == HOLD;
    assign instr       = instr_valid ? instr_q : NOP_INSTR;

    always_comb begin
        state_n = state;
        case (state)
            RST:     state_n = FETCH;
            FETCH:   state_n = WAIT;
            WAIT:    state_n = imem_rvalid ? HOLD : WAIT;
            HOLD:    state_n = accept ? (stop ? HALT : FETCH) : HOLD;
            default: state_n = HALT;
        endcase
    end

    // finish outranks a misaligned target, so an ECALL never raises fetch_err
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RST;
            pc        <= RESET_PC;
            instr_q   <= NOP_INSTR;
            halted    <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            state <= state_n;
            if (state == WAIT && imem_rvalid) instr_q <= imem_rdata;
            if (accept && !stop) pc <= npc;
            if (accept && stop) halted <= 1'b1;
            if (accept && !finish && misaligned) fetch_err <= 1'b1;
        end
    end
endmodule
